video_scanout_1bpp: RTL and testbench

Monochrome framebuffer scan-out stage in the pixel-clock domain. It generates 1024x768 display timing, pulls 32-bit framebuffer words from an upstream memory fetcher through a valid/ready stream, and serialises them into the 2-bit RGB, sync and blank signals consumed directly by the VGA-to-DVI encoder. The block has no memory port and no CDC logic; the upstream fetcher and its async FIFO own both.

---
 rtl/video_scanout_1bpp.sv | 197 +++++++++++++++++++
 tb/tb_video_scanout_1bpp.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/video_scanout_1bpp.sv
`default_nettype none
// ============================================================================
// Module   : video_scanout_1bpp
// Desc     : 1bpp framebuffer scan-out: display timing, word prefetch FIFO and
//            pixel serialiser. Define VIDEO_TEST_PATTERN_EN for a checkerboard.
// Revision : 1.0  initial release
// ============================================================================
module video_scanout_1bpp #(
  parameter int H_RES      = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_RES      = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter int SYNC_POL   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
`ifdef VIDEO_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic        in_ready,
  output logic        fb_sof,
  output logic        underflow,
  output logic [1:0]  vga_r,
  output logic [1:0]  vga_g,
  output logic [1:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int HW_RAW  = $clog2(H_TOTAL);
  localparam int VW_RAW  = $clog2(V_TOTAL);
  // At least 6 bits so the checkerboard can always address bit 5.
  localparam int HW      = (HW_RAW < 6) ? 6 : HW_RAW;
  localparam int VW      = (VW_RAW < 6) ? 6 : VW_RAW;
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] C_H_ONE    = HW'(1);
  localparam logic [HW-1:0] C_H_ACT    = HW'(H_RES);
  localparam logic [HW-1:0] C_HS_BEG   = HW'(H_RES + H_FP);
  localparam logic [HW-1:0] C_HS_END   = HW'(H_RES + H_FP + H_SYNC);
  localparam logic [HW-1:0] C_H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] C_V_ONE    = VW'(1);
  localparam logic [VW-1:0] C_V_ACT    = VW'(V_RES);
  localparam logic [VW-1:0] C_VS_BEG   = VW'(V_RES + V_FP);
  localparam logic [VW-1:0] C_VS_END   = VW'(V_RES + V_FP + V_SYNC);
  localparam logic [VW-1:0] C_V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [AW:0]   C_PTR_ONE  = (AW+1)'(1);
  localparam logic          C_SYNC_ACT = (SYNC_POL != 0);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   word_q, word_d;
  logic [1:0]    colour_q, colour_d;
  logic          blank_q, blank_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          sof_q, sof_d;
  logic          under_q, under_d;

  logic          w_active;
  logic          w_pop_pt;
  logic          w_sof_now;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_tp;
  logic [31:0]   w_fill_word;
  logic [31:0]   w_cur_word;
  logic          w_word_bit;
  logic          w_bit;

  assign w_active  = (h_q < C_H_ACT) && (v_q < C_V_ACT);
  assign w_pop_pt  = w_active && (h_q[4:0] == 5'd0);
  assign w_sof_now = (h_q == '0) && (v_q == C_V_LAST);

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

`ifdef VIDEO_TEST_PATTERN_EN
  assign w_tp = test_pattern;
`else
  assign w_tp = 1'b0;
`endif

  // The sof cycle (registered fb_sof high) flushes stale prefetch, so nothing
  // may be accepted in that same cycle.
  assign in_ready = w_tp | (~w_full & ~sof_q);
  assign w_push   = in_valid & in_ready & ~w_tp;
  assign w_pop    = w_pop_pt & ~w_empty & ~w_tp;

  // An empty FIFO at a pop point blanks the whole 32-pixel group.
  assign w_fill_word = w_empty ? 32'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign w_cur_word  = w_pop_pt ? w_fill_word : word_q;
  assign w_word_bit  = w_cur_word[h_q[4:0]];

`ifdef VIDEO_TEST_PATTERN_EN
  assign w_bit = w_tp ? (h_q[5] ^ v_q[5]) : w_word_bit;
`else
  assign w_bit = w_word_bit;
`endif

  always_comb begin
    h_d = h_q + C_H_ONE;
    v_d = v_q;
    if (h_q == C_H_LAST) begin
      h_d = '0;
      v_d = (v_q == C_V_LAST) ? '0 : (v_q + C_V_ONE);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (sof_q) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      if (w_pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end
  end

  always_comb begin
    word_d = word_q;
    if (w_pop_pt && !w_tp) word_d = w_fill_word;
  end

  always_comb begin
    colour_d = (w_active && w_bit) ? 2'b11 : 2'b00;
    blank_d  = ~w_active;
    hsync_d  = ((h_q >= C_HS_BEG) && (h_q < C_HS_END)) ? C_SYNC_ACT : ~C_SYNC_ACT;
    vsync_d  = ((v_q >= C_VS_BEG) && (v_q < C_VS_END)) ? C_SYNC_ACT : ~C_SYNC_ACT;
    sof_d    = w_sof_now;
    under_d  = under_q;
    if (w_sof_now)                       under_d = 1'b0;
    else if (w_pop_pt && w_empty && !w_tp) under_d = 1'b1;
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      h_q      <= '0;
      v_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      word_q   <= '0;
      colour_q <= 2'b00;
      blank_q  <= 1'b1;
      hsync_q  <= ~C_SYNC_ACT;
      vsync_q  <= ~C_SYNC_ACT;
      sof_q    <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      word_q   <= word_d;
      colour_q <= colour_d;
      blank_q  <= blank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      sof_q    <= sof_d;
      under_q  <= under_d;
    end
  end

  // Storage needs no reset: occupancy is fully defined by the pointers.
  always_ff @(posedge clk_pixel) begin
    if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

  assign vga_r     = colour_q;
  assign vga_g     = colour_q;
  assign vga_b     = colour_q;
  assign vga_blank = blank_q;
  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign fb_sof    = sof_q;
  assign underflow = under_q;

endmodule
`default_nettype wire

// File: tb/tb_video_scanout_1bpp.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_scanout_1bpp
// Desc     : Scoreboard bench for video_scanout_1bpp on a reduced raster.
// Revision : 1.0  initial release
// ============================================================================
module tb_video_scanout_1bpp;

  localparam int HR = 64, HFP = 4, HS = 8, HBP = 12;
  localparam int VR = 8,  VFP = 2, VS = 3, VBP = 3;
  localparam int SP = 0, D = 4;
  localparam int HT = HR + HFP + HS + HBP;
  localparam int VT = VR + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam logic SPL = (SP != 0);
  localparam logic NSP = (SP == 0);
  localparam logic [10:0] RST_EXP = {6'b0, 1'b1, NSP, NSP, 2'b00};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready, fb_sof, underflow;
  logic [1:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, vga_blank;
`ifdef VIDEO_TEST_PATTERN_EN
  logic        test_pattern = 1'b0;
`endif

  video_scanout_1bpp #(
    .H_RES(HR), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_RES(VR), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(SP), .FIFO_DEPTH(D)
  ) dut (
    .clk_pixel(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
`ifdef VIDEO_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .in_ready(in_ready),
    .fb_sof(fb_sof),
    .underflow(underflow),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .vga_blank(vga_blank)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          mh, mv, mode, widx;
  logic [31:0] mq [$];
  logic [31:0] mword;
  logic        munder, msof;
  logic [10:0] sb [$];
  bit          cnt_en = 1'b0;
  int          hs_low = 0, vs_low = 0, sof_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h (h=%0d v=%0d t=%0t)", tag, obs, exp, mh, mv, $time);
    end
  endtask

  task automatic model_init();
    mh = 0; mv = 0; mword = 32'd0; munder = 1'b0; msof = 1'b0;
    mq.delete();
    sb.delete();
    sb.push_back(RST_EXP);
  endtask

  // Called at a negedge: check outputs, drive inputs, advance model, wait edge.
  task automatic cycle();
    logic [10:0] obs, e;
    logic [31:0] cur;
    logic [1:0]  col;
    logic        act, popp, sofn, rdy, push, hs, vs, und_n, bitv;
    obs = {vga_r, vga_g, vga_b, vga_blank, vga_hsync, vga_vsync, fb_sof, underflow};
    if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      check("out", 32'(obs), 32'(e));
    end
    rdy = (mq.size() < D) && !msof;
    check("in_ready", 32'(in_ready), 32'(rdy));
    if (cnt_en) begin
      if (vga_hsync == SPL) hs_low++;
      if (vga_vsync == SPL) vs_low++;
      if (fb_sof) sof_cnt++;
    end

    if (fb_sof) widx = 0;
    case (mode)
      1: begin in_valid = 1'b1; in_data = (widx == 0) ? 32'h0000_0001 : 32'd0; end
      2: begin in_valid = 1'b1; in_data = widx[0] ? 32'd0 : 32'hFFFF_FFFF; end
      3: begin in_valid = (widx < 1); in_data = in_valid ? 32'hA5A5_5A5A : 32'd0; end
      4: begin in_valid = ($urandom_range(0, 3) != 0); in_data = $urandom; end
      default: begin in_valid = 1'b0; in_data = 32'd0; end
    endcase
    if (in_valid && in_ready) widx++;

    act  = (mh < HR) && (mv < VR);
    popp = act && ((mh % 32) == 0);
    sofn = (mh == 0) && (mv == VT - 1);
    push = in_valid && rdy;
    if (popp) cur = (mq.size() == 0) ? 32'd0 : mq[0];
    else      cur = mword;
    bitv  = cur[mh % 32];
    col   = (act && bitv) ? 2'b11 : 2'b00;
    hs    = ((mh >= HR + HFP) && (mh < HR + HFP + HS)) ? SPL : NSP;
    vs    = ((mv >= VR + VFP) && (mv < VR + VFP + VS)) ? SPL : NSP;
    und_n = sofn ? 1'b0 : ((popp && mq.size() == 0) ? 1'b1 : munder);
    sb.push_back({col, col, col, !act, hs, vs, sofn, und_n});

    if (popp) mword = (mq.size() == 0) ? 32'd0 : mq.pop_front();
    if (msof) mq.delete();
    else if (push) mq.push_back(in_data);
    munder = und_n;
    msof   = sofn;
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) mv = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 32'd0;
    #1;
    check("rst_rgb",   32'({vga_r, vga_g, vga_b}), 32'd0);
    check("rst_blank", 32'(vga_blank), 32'd1);
    check("rst_sync",  32'({vga_hsync, vga_vsync}), 32'({NSP, NSP}));
    check("rst_sof_und", 32'({fb_sof, underflow}), 32'd0);
    check("rst_rdy",   32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_init();
  endtask

  initial begin
    mode = 0; widx = 0;
    #2;
    do_reset();

    // Idle timing over two frames.
    cnt_en = 1'b1;
    repeat (2 * FRAME) cycle();
    cnt_en = 1'b0;
    check("sof_cnt", 32'(sof_cnt), 32'd2);
    check("hs_low",  32'(hs_low),  32'(2 * VT * HS));
    check("vs_low",  32'(vs_low),  32'(2 * VS * HT));

    mode = 1; repeat (2 * FRAME) cycle();   // pixel order
    mode = 2; repeat (2 * FRAME) cycle();   // stripes, FIFO full at sof
    mode = 3; repeat (2 * FRAME) cycle();   // starved fetcher
    mode = 4; repeat (2 * FRAME) cycle();   // random valid gaps
    mode = 2; repeat (FRAME) cycle();       // recover from underflow

    for (int i = 0; i < 2 * FRAME && !(mh == 40 && mv == 5); i++) cycle();
    check("mid_reach", 32'(mh == 40 && mv == 5), 32'd1);
    do_reset();
    mode = 2;
    repeat (FRAME + 2 * HT) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
